// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: boot-slot select, sequential step, stall, branch load,
// and (with PC_IRQ_EN defined) a single-level vectored interrupt with EPC and eret.
module pc_sequencer #(
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] STEP        = 1,
   parameter int               PROGR_W     = 2,
   parameter int               NUM_BOOT    = 3,
   parameter logic [WIDTH-1:0] BOOT_BASE   = 0,
   parameter logic [WIDTH-1:0] BOOT_STRIDE = 15,
   parameter logic [WIDTH-1:0] IRQ_VECTOR  = 'h80
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [PROGR_W-1:0] progr,
   input  logic               stall,
   input  logic               branch_valid,
   input  logic [WIDTH-1:0]   address,
   input  logic               interrupt,
   input  logic               eret,
   output logic [WIDTH-1:0]   program_counter,
   output logic [WIDTH-1:0]   epc,
   output logic               valid,
   output logic               in_isr,
   output logic               irq_ack
);

`ifdef PC_IRQ_EN
   typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, ISR = 2'd2} state_t;
`else
   typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1} state_t;
`endif

   localparam logic [31:0] NUM_BOOT_U = NUM_BOOT;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] pc_q, pc_nxt;
   logic [WIDTH-1:0] pc_inc;
   logic [WIDTH-1:0] boot_addr;
   logic             boot_in_range;

   assign pc_inc        = pc_q + STEP;
   // product truncated to WIDTH, so oversize strides wrap like any other PC arithmetic
   assign boot_addr     = BOOT_BASE + WIDTH'(progr) * BOOT_STRIDE;
   assign boot_in_range = 32'(progr) < NUM_BOOT_U;

`ifdef PC_IRQ_EN
   logic [WIDTH-1:0] epc_q, epc_nxt;
   logic             ack_q, ack_nxt;

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc_q;
      epc_nxt   = epc_q;
      ack_nxt   = 1'b0;
      case (state)
         BOOT: begin
            pc_nxt    = boot_in_range ? boot_addr : address;
            state_nxt = RUN;
         end
         RUN: begin
            if (!stall) begin
               if (interrupt) begin
                  // return to the instruction that would have run next
                  epc_nxt   = branch_valid ? address : pc_inc;
                  pc_nxt    = IRQ_VECTOR;
                  ack_nxt   = 1'b1;
                  state_nxt = ISR;
               end else if (branch_valid) begin
                  pc_nxt = address;
               end else begin
                  pc_nxt = pc_inc;
               end
            end
         end
         ISR: begin
            if (!stall) begin
               if (eret) begin
                  pc_nxt    = epc_q;
                  state_nxt = RUN;
               end else if (branch_valid) begin
                  pc_nxt = address;
               end else begin
                  pc_nxt = pc_inc;
               end
            end
         end
         default: state_nxt = BOOT;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= BOOT;
         pc_q  <= '0;
         epc_q <= '0;
         ack_q <= 1'b0;
      end else begin
         state <= state_nxt;
         pc_q  <= pc_nxt;
         epc_q <= epc_nxt;
         ack_q <= ack_nxt;
      end
   end

   assign epc     = epc_q;
   assign irq_ack = ack_q;
   assign in_isr  = (state == ISR);
`else
   logic unused_irq_inputs;
   assign unused_irq_inputs = interrupt ^ eret;

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc_q;
      case (state)
         BOOT: begin
            pc_nxt    = boot_in_range ? boot_addr : address;
            state_nxt = RUN;
         end
         RUN: begin
            if (!stall) begin
               if (branch_valid) pc_nxt = address;
               else              pc_nxt = pc_inc;
            end
         end
         default: state_nxt = BOOT;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= BOOT;
         pc_q  <= '0;
      end else begin
         state <= state_nxt;
         pc_q  <= pc_nxt;
      end
   end

   assign epc     = '0;
   assign irq_ack = 1'b0;
   assign in_isr  = 1'b0;
`endif

   assign program_counter = pc_q;
   assign valid           = (state != BOOT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; the interrupt section follows whether PC_IRQ_EN is defined.
module tb_pc_sequencer;
   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  progr;
   logic        stall;
   logic        branch_valid;
   logic [31:0] address;
   logic        interrupt;
   logic        eret;
   logic [31:0] program_counter;
   logic [31:0] epc;
   logic        valid;
   logic        in_isr;
   logic        irq_ack;

   int errors = 0;
   int checks = 0;

   pc_sequencer dut (
      .clock(clock), .reset(reset), .progr(progr), .stall(stall),
      .branch_valid(branch_valid), .address(address), .interrupt(interrupt),
      .eret(eret), .program_counter(program_counter), .epc(epc),
      .valid(valid), .in_isr(in_isr), .irq_ack(irq_ack)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic boot_with(input logic [1:0] p, input logic [31:0] exp_pc);
      reset = 1'b1;
      progr = p;
      #2;
      reset = 1'b0;
      check("valid_pre_boot", {31'b0, valid}, 32'd0);
      tick();
      check("boot_pc", program_counter, exp_pc);
      check("boot_valid", {31'b0, valid}, 32'd1);
   endtask

   initial begin
      reset = 1'b1; progr = 2'd0; stall = 1'b0; branch_valid = 1'b0;
      address = 32'h1234; interrupt = 1'b0; eret = 1'b0;
      #1;
      check("rst_pc", program_counter, 32'd0);
      check("rst_epc", epc, 32'd0);
      check("rst_valid", {31'b0, valid}, 32'd0);
      check("rst_in_isr", {31'b0, in_isr}, 32'd0);
      check("rst_irq_ack", {31'b0, irq_ack}, 32'd0);
      tick();
      check("rst_hold_pc", program_counter, 32'd0);

      boot_with(2'd0, 32'd0);
      boot_with(2'd1, 32'd15);
      boot_with(2'd3, 32'h1234);
      boot_with(2'd2, 32'd30);

      for (int i = 1; i <= 5; i++) begin
         tick();
         check("incr", program_counter, 32'd30 + 32'(i));
      end
      stall = 1'b1;
      tick(); check("stall1", program_counter, 32'd35);
      tick(); check("stall2", program_counter, 32'd35);
      stall = 1'b0;

      branch_valid = 1'b1; address = 32'd40;
      tick(); check("br_40", program_counter, 32'd40);
      address = 32'h200;
      tick(); check("br_200", program_counter, 32'h200);
      address = 32'hFFFF_FFFF;
      tick(); check("br_max", program_counter, 32'hFFFF_FFFF);
      branch_valid = 1'b0;
      tick(); check("wrap", program_counter, 32'd0);

      branch_valid = 1'b1; address = 32'd50;
      tick(); check("br_50", program_counter, 32'd50);
      branch_valid = 1'b0;

`ifdef PC_IRQ_EN
      interrupt = 1'b1;
      tick();
      check("irq_pc", program_counter, 32'h80);
      check("irq_epc", epc, 32'd51);
      check("irq_ack", {31'b0, irq_ack}, 32'd1);
      check("irq_in_isr", {31'b0, in_isr}, 32'd1);
      interrupt = 1'b0;
      tick();
      check("isr_pc1", program_counter, 32'h81);
      check("ack_pulse", {31'b0, irq_ack}, 32'd0);
      tick(); check("isr_pc2", program_counter, 32'h82);
      tick(); check("isr_pc3", program_counter, 32'h83);
      eret = 1'b1;
      tick();
      check("eret_pc", program_counter, 32'd51);
      check("eret_in_isr", {31'b0, in_isr}, 32'd0);
      eret = 1'b0;

      interrupt = 1'b1;
      tick();
      check("irq2_pc", program_counter, 32'h80);
      check("irq2_epc", epc, 32'd52);
      tick();
      check("no_nest_pc", program_counter, 32'h81);
      check("no_nest_ack", {31'b0, irq_ack}, 32'd0);
      check("no_nest_epc", epc, 32'd52);
      eret = 1'b1;
      tick();
      check("eret_wins_pc", program_counter, 32'd52);
      check("eret_wins_isr", {31'b0, in_isr}, 32'd0);
      check("eret_wins_ack", {31'b0, irq_ack}, 32'd0);
      eret = 1'b0;
      tick();
      check("reirq_pc", program_counter, 32'h80);
      check("reirq_epc", epc, 32'd53);
      check("reirq_ack", {31'b0, irq_ack}, 32'd1);

      interrupt = 1'b0; eret = 1'b1;
      tick(); check("eret3_pc", program_counter, 32'd53);
      eret = 1'b0; stall = 1'b1; interrupt = 1'b1;
      tick();
      check("stall_irq_pc", program_counter, 32'd53);
      check("stall_irq_ack", {31'b0, irq_ack}, 32'd0);
      check("stall_irq_isr", {31'b0, in_isr}, 32'd0);
      stall = 1'b0;
      tick();
      check("defer_irq_pc", program_counter, 32'h80);
      check("defer_irq_epc", epc, 32'd54);
      check("defer_irq_ack", {31'b0, irq_ack}, 32'd1);

      #2;
      reset = 1'b1;
      #1;
      check("async_pc", program_counter, 32'd0);
      check("async_epc", epc, 32'd0);
      check("async_in_isr", {31'b0, in_isr}, 32'd0);
      check("async_valid", {31'b0, valid}, 32'd0);
      check("async_ack", {31'b0, irq_ack}, 32'd0);
`else
      interrupt = 1'b1;
      tick();
      check("noirq_pc", program_counter, 32'd51);
      check("noirq_ack", {31'b0, irq_ack}, 32'd0);
      check("noirq_in_isr", {31'b0, in_isr}, 32'd0);
      check("noirq_epc", epc, 32'd0);
      eret = 1'b1;
      tick();
      check("noirq_eret_pc", program_counter, 32'd52);
      check("noirq_ack2", {31'b0, irq_ack}, 32'd0);
      #2;
      reset = 1'b1;
      #1;
      check("async_pc", program_counter, 32'd0);
      check("async_valid", {31'b0, valid}, 32'd0);
`endif
      interrupt = 1'b0; eret = 1'b0;
      tick();
      check("rst_held_pc", program_counter, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
